// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus arbitration bundle: per-device requests, grants and data/control
// slices, plus the multiplexed bus outputs. The slave side is the arbiter.
interface bus_arbiter_rr_if #(
    parameter int NUM_DEVICES = 8,
    parameter int D_WIDTH     = 32,
    parameter int C_WIDTH     = 8,
    parameter int IDX_WIDTH   = 3
);
    logic [NUM_DEVICES-1:0]         req;
    logic [NUM_DEVICES-1:0]         ack;
    logic [NUM_DEVICES*D_WIDTH-1:0] bus_in;
    logic [NUM_DEVICES*C_WIDTH-1:0] ctrl_in;
    logic [D_WIDTH-1:0]             bus_out;
    logic [C_WIDTH-1:0]             ctrl_out;
    logic [IDX_WIDTH-1:0]           owner;
    logic                           busy;
    logic                           timeout_evt;

    modport master (
        output req, bus_in, ctrl_in,
        input  ack, bus_out, ctrl_out, owner, busy, timeout_evt
    );

    modport slave (
        input  req, bus_in, ctrl_in,
        output ack, bus_out, ctrl_out, owner, busy, timeout_evt
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with tenure limit and one-cycle turnaround.
// Ports: clk, reset (sync, active-high), bus (slave side of bus_arbiter_rr_if).
module bus_arbiter_rr #(
    parameter int NUM_DEVICES = 8,
    parameter int D_WIDTH     = 32,
    parameter int C_WIDTH     = 8,
    parameter int IDX_WIDTH   = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             reset,
    bus_arbiter_rr_if.slave  bus
);
    localparam int TCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   owner_q, owner_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
    logic [NUM_DEVICES-1:0] ack_q, ack_d;
    logic                   tevt_q, tevt_d;

    logic [IDX_WIDTH-1:0]   win;
    logic                   any_req;
    logic                   req_own;
    logic                   tmo_hit;

    // Circular scan from ptr; walking offsets downward lets the
    // smallest offset (highest priority) be the final writer.
    always_comb begin
        int idx;
        idx     = 0;
        win     = ptr_q;
        any_req = 1'b0;
        for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NUM_DEVICES;
            if (bus.req[idx]) begin
                win     = IDX_WIDTH'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign req_own = bus.req[owner_q];
    assign tmo_hit = (TIMEOUT != 0) && (tcnt_q == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            tcnt_q  <= '0;
            ack_q   <= '0;
            tevt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
            ack_q   <= ack_d;
            tevt_q  <= tevt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        tcnt_d  = tcnt_q;
        ack_d   = ack_q;
        tevt_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    owner_d = win;
                    ack_d   = NUM_DEVICES'(1) << win;
                    tcnt_d  = '0;
                end
            end
            GRANT: begin
                // A release on the limit cycle wins over the timeout.
                unique case (1'b1)
                    !req_own: begin
                        state_d = TURN;
                        ack_d   = '0;
                    end
                    req_own && tmo_hit: begin
                        state_d = TURN;
                        ack_d   = '0;
                        tevt_d  = 1'b1;
                    end
                    default: tcnt_d = tcnt_q + 1'b1;
                endcase
            end
            TURN: begin
                state_d = IDLE;
                ptr_d   = (owner_q == IDX_WIDTH'(NUM_DEVICES - 1))
                        ? '0 : owner_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack         = ack_q;
        bus.owner       = owner_q;
        bus.busy        = (state_q == GRANT);
        bus.timeout_evt = tevt_q;
        bus.bus_out     = '0;
        bus.ctrl_out    = '0;
        if (state_q == GRANT) begin
            bus.bus_out  = bus.bus_in[int'(owner_q)*D_WIDTH +: D_WIDTH];
            bus.ctrl_out = bus.ctrl_in[int'(owner_q)*C_WIDTH +: C_WIDTH];
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr: directed scenarios plus random traffic,
// every cycle compared against a tenure-level reference model.
module tb_bus_arbiter_rr;
    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int CW  = 8;
    localparam int IW  = 3;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bus_arbiter_rr_if #(
        .NUM_DEVICES(N), .D_WIDTH(DW), .C_WIDTH(CW), .IDX_WIDTH(IW)
    ) bus ();

    bus_arbiter_rr #(
        .NUM_DEVICES(N), .D_WIDTH(DW), .C_WIDTH(CW),
        .IDX_WIDTH(IW), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who holds the bus, for how many cycles so far,
    // how many forced idle cycles remain, and who has top priority.
    bit m_valid = 0;
    int m_own   = 0;
    int m_held  = 0;
    int m_cool  = 0;
    int m_ptr   = 0;
    bit m_evt   = 0;
    bit m_new   = 0;

    task automatic model_edge();
        bit found;
        int d;
        m_evt = 0;
        m_new = 0;
        if (rst) begin
            m_valid = 0; m_own = 0; m_held = 0;
            m_cool = 0; m_ptr = 0;
        end else if (m_valid) begin
            m_held++;
            if (!bus.req[m_own] || (TMO != 0 && m_held == TMO)) begin
                m_evt   = bus.req[m_own];
                m_valid = 0;
                m_cool  = 1;
                m_ptr   = (m_own + 1) % N;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                d = (m_ptr + k) % N;
                if (!found && bus.req[d]) begin
                    found = 1; m_valid = 1; m_own = d;
                    m_held = 0; m_new = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [N-1:0]  ea;
        logic [DW-1:0] eb;
        logic [CW-1:0] ec;
        ea = m_valid ? (N'(1) << m_own) : '0;
        eb = m_valid ? bus.bus_in[m_own*DW +: DW] : '0;
        ec = m_valid ? bus.ctrl_in[m_own*CW +: CW] : '0;
        check("ack", bus.ack, ea);
        check("owner", bus.owner, m_own);
        check("busy", bus.busy, m_valid);
        check("bus_out", bus.bus_out, eb);
        check("ctrl_out", bus.ctrl_out, ec);
        check("timeout_evt", bus.timeout_evt, m_evt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            bus.bus_in[i*DW +: DW]  = $urandom();
            bus.ctrl_in[i*CW +: CW] = CW'($urandom());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        step();
        rst = 1'b0;
    endtask

    int acked[N];
    int off[N];
    int order[$];
    int exp_rr[5] = '{0, 3, 6, 0, 3};
    logic [N-1:0] tbl_ack[11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                                  8'h00, 8'h08, 8'h08, 8'h00, 8'h00,
                                  8'h01};
    bit tbl_evt[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        logic [N-1:0] r;
        bus.req = '0;
        bus.bus_in = '0;
        bus.ctrl_in = '0;
        @(negedge clk);

        // Reset state
        step();
        step();
        check("rst_ack", bus.ack, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_bus_out", bus.bus_out, 0);
        rst = 1'b0;

        // Single request from ID 7; release coincides with limit cycle
        rand_data();
        bus.bus_in[7*DW +: DW]  = 32'h0000_1234;
        bus.ctrl_in[7*CW +: CW] = 8'hA5;
        bus.req = 8'h80;
        step();
        check("single_ack", bus.ack, 8'h80);
        check("single_bus", bus.bus_out, 32'h1234);
        check("single_ctrl", bus.ctrl_out, 8'hA5);
        check("single_owner", bus.owner, 7);
        check("single_busy", bus.busy, 1);
        repeat (3) begin
            step();
            check("single_hold", bus.ack, 8'h80);
        end
        bus.req = '0;
        step();
        check("single_rel", bus.ack, 0);
        check("single_no_evt", bus.timeout_evt, 0);
        step();
        check("single_gap", bus.ack, 0);
        check("single_owner_hold", bus.owner, 7);

        // Round robin over IDs 0, 3, 6 (priority now starts at 0)
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            foreach (exp_rr[j]) begin
                if (j < 3) begin
                    bus.req[exp_rr[j]] = (off[exp_rr[j]] == 0);
                    if (off[exp_rr[j]] > 0) off[exp_rr[j]]--;
                end
            end
            step();
            if (m_new) order.push_back(m_own);
            if (m_valid) begin
                acked[m_own]++;
                if (acked[m_own] == 3) begin
                    acked[m_own] = 0;
                    off[m_own] = 1;
                end
            end
        end
        check("rr_count", order.size(), 5);
        for (int i = 0; i < 5; i++)
            check("rr_order", (i < order.size()) ? order[i] : 99, exp_rr[i]);

        // Timeout with a competing requester
        do_reset();
        bus.req = 8'h09;
        for (int i = 0; i < 11; i++) begin
            if (i == 8) bus.req = 8'h01;
            step();
            check("to_ack", bus.ack, tbl_ack[i]);
            check("to_evt", bus.timeout_evt, tbl_evt[i]);
        end

        // Sole requester repeatedly timed out and re-granted
        do_reset();
        bus.req = 8'h04;
        for (int i = 0; i < 14; i++) begin
            step();
            check("sole_ack", bus.ack, (i % 6 < 4) ? 8'h04 : 8'h00);
            check("sole_evt", bus.timeout_evt, (i % 6 == 4));
        end

        // Reset during GRANT
        do_reset();
        rand_data();
        bus.req = 8'h10;
        step();
        check("mid_ack", bus.ack, 8'h10);
        step();
        rst = 1'b1;
        bus.req = 8'hFF;
        step();
        check("rstg_ack", bus.ack, 0);
        check("rstg_busy", bus.busy, 0);
        check("rstg_bus", bus.bus_out, 0);
        check("rstg_ctrl", bus.ctrl_out, 0);
        check("rstg_evt", bus.timeout_evt, 0);
        rst = 1'b0;
        step();
        check("rstg_regrant", bus.ack, 8'h01);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            r = bus.req;
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, N-1)] ^= 1'b1;
            bus.req = r;
            rand_data();
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
